if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC loaded on reset.
REQ-002 clock  input  1  system clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 fetch_en  input  1  when low, no new memory request is issued; an outstanding request still completes.
REQ-005 imem_req_valid  output  1  instruction-memory read request.
REQ-006 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-007 imem_addr  output  32  word-aligned request address; bits [1:0] are always 0.
REQ-008 imem_rsp_valid  input  1  read data valid; at most one per accepted request.
REQ-009 imem_rsp_data  input  32  fetched instruction word.
REQ-010 ex_take_branch  input  1  one-cycle redirect pulse from execute.
REQ-011 ex_target_pc  input  32  redirect target; bits [1:0] are ignored and treated as 0.
REQ-012 id_ready  input  1  decode consumes the output register this cycle.
REQ-013 if_inst  output  32  instruction presented to the decoder's inst input.
REQ-014 if_valid_inst  output  1  drives the decoder's valid_inst_in.
REQ-015 if_pc / if_npc  output  32 each  address of if_inst and that address + 4.

Function
REQ-016 FSM states: S_REQ (request issue), S_WAIT (response pending); at most one request is outstanding.
REQ-017 In S_REQ, imem_req_valid = fetch_en & (~if_valid_inst | id_ready), and imem_addr = pc.
REQ-018 In S_REQ, a handshake (imem_req_valid & imem_req_ready) moves the FSM to S_WAIT; imem_req_valid stays high until the handshake completes.
REQ-019 In S_WAIT, imem_req_valid = 0; on imem_rsp_valid with no drop pending: if_inst <= data, if_pc <= pc, if_valid_inst <= 1, pc <= pc + 4, FSM -> S_REQ.
REQ-020 A response arrives only when the output register is empty or being consumed in that cycle (guaranteed by REQ-017); responses are never back-pressured.
REQ-021 When id_ready & if_valid_inst and no new instruction is loaded, if_valid_inst <= 0 on the next edge.
REQ-022 When if_valid_inst = 1 and id_ready = 0, if_inst, if_pc, and if_valid_inst hold their values.
REQ-023 On ex_take_branch: pc <= {ex_target_pc[31:2], 2'b00} and if_valid_inst <= 0; redirect has priority over all other updates.
REQ-024 Redirect in S_WAIT with no response in the same cycle: set drop flag; the next response is discarded, the drop flag is cleared, and the FSM -> S_REQ.
REQ-025 Redirect in the same cycle as a response: the response is discarded and the FSM -> S_REQ.
REQ-026 Redirect in the same cycle as an S_REQ handshake: FSM -> S_WAIT with the drop flag set.
REQ-027 Redirect in S_REQ without a handshake: the next request uses the new pc.
REQ-028 pc + 4 wraps modulo 2^32; if_npc = if_pc + 4 with the same wrap.
REQ-029 Fetch latency: imem_rsp_valid in cycle N makes if_valid_inst = 1 in cycle N+1.

Reset
REQ-030 reset_n low asynchronously forces pc = RESET_PC, FSM = S_REQ, drop flag = 0, if_valid_inst = 0, if_inst = 32'h0000_0013 (addi x0,x0,0), and if_pc = if_npc - 4 = RESET_PC.
REQ-031 A response that arrives for a request issued before reset, while reset is asserted, is ignored.
REQ-032 After reset_n deasserts, imem_req_valid may assert on the first edge with fetch_en = 1.

Structure
REQ-033 State encoding (S_REQ/S_WAIT), the NOP constant, and the PC width belong in the shared sys_defs package, next to the existing opcode defines.
REQ-034 The design is a single module with no sub-modules; the PC-increment adder is shared between pc and if_npc.

Verification
REQ-035 Reset, then fetch_en = 1, memory ready at zero latency returning 0x00000013 -> first imem_addr = RESET_PC, if_valid_inst rises, if_pc = RESET_PC, next imem_addr = RESET_PC + 4.
REQ-036 id_ready = 0 for 5 cycles with if_valid_inst = 1 -> if_inst and if_pc stable, no new request issued; id_ready = 1 -> next request issued in the same cycle.
REQ-037 Redirect to 0x100 while in S_WAIT, then a 3-cycle-late response 0xDEADBEEF -> response dropped, if_valid_inst stays 0, next imem_addr = 0x100.
REQ-038 Redirect to 0x203 coincident with a response -> response discarded, next imem_addr = 0x200.
REQ-039 pc = 0xFFFF_FFFC fetch -> if_npc = 0x0000_0000, next imem_addr = 0x0.
REQ-040 reset_n asserted mid-S_WAIT -> all outputs at reset values immediately, before the next clock edge; a late response is ignored.

Source files
------------

// File: rtl/sys_defs.sv
// Shared machine definitions: opcodes, PC width, fetch FSM encoding and the canonical NOP.
package sys_defs;

  localparam int PC_W = 32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = {12'h000, 5'd0, 3'b000, 5'd0, OPC_OP_IMM};

  typedef enum logic {
    S_REQ  = 1'b0,
    S_WAIT = 1'b1
  } if_state_e;

endpackage

// File: rtl/if_stage.sv
// Instruction fetch stage: single-outstanding memory request FSM feeding a one-entry
// output register to decode, with execute-stage redirect and in-flight response drop.
module if_stage
  import sys_defs::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            fetch_en,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            ex_take_branch,
  input  logic [PC_W-1:0] ex_target_pc,
  input  logic            id_ready,
  output logic [31:0]     if_inst,
  output logic            if_valid_inst,
  output logic [PC_W-1:0] if_pc,
  output logic [PC_W-1:0] if_npc
);

  localparam logic [PC_W-1:0] RESET_NPC = RESET_PC + PC_W'(4);

  if_state_e       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic [31:0]     if_inst_q, if_inst_d;
  logic [PC_W-1:0] if_pc_q, if_pc_d;
  logic [PC_W-1:0] if_npc_q, if_npc_d;
  logic            if_valid_q, if_valid_d;

  logic            req_valid;
  logic            handshake;
  logic            load;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] redirect_pc;

  // The one adder: pc + 4 becomes both the next fetch pc and the registered if_npc.
  assign pc_inc      = pc_q + PC_W'(4);
  assign redirect_pc = {ex_target_pc[PC_W-1:2], 2'b00};

  // Request is held off while the output register is full and not draining, so a
  // response always has somewhere to land. Gated by reset so outputs are quiet in reset.
  assign req_valid = reset_n && (state_q == S_REQ) && fetch_en && (!if_valid_q || id_ready);
  assign handshake = req_valid && imem_req_ready;
  assign load      = (state_q == S_WAIT) && imem_rsp_valid && !drop_q && !ex_take_branch;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    if_inst_d  = if_inst_q;
    if_pc_d    = if_pc_q;
    if_npc_d   = if_npc_q;
    if_valid_d = if_valid_q;

    case (state_q)
      S_REQ: begin
        if (handshake) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          state_d = S_REQ;
          drop_d  = 1'b0;
        end
      end
      default: state_d = S_REQ;
    endcase

    if (load) begin
      if_inst_d  = imem_rsp_data;
      if_pc_d    = pc_q;
      if_npc_d   = pc_inc;
      pc_d       = pc_inc;
      if_valid_d = 1'b1;
    end else if (id_ready && if_valid_q) begin
      if_valid_d = 1'b0;
    end

    // A redirect overrides everything; any request already in flight is marked stale.
    if (ex_take_branch) begin
      pc_d       = redirect_pc;
      if_valid_d = 1'b0;
      if (state_q == S_REQ) begin
        drop_d = handshake;
      end else if (!imem_rsp_valid) begin
        drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      drop_q     <= 1'b0;
      if_inst_q  <= NOP_INST;
      if_pc_q    <= RESET_PC;
      if_npc_q   <= RESET_NPC;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      if_inst_q  <= if_inst_d;
      if_pc_q    <= if_pc_d;
      if_npc_q   <= if_npc_d;
      if_valid_q <= if_valid_d;
    end
  end

  assign imem_req_valid = req_valid;
  assign imem_addr      = {pc_q[PC_W-1:2], 2'b00};
  assign if_inst        = if_inst_q;
  assign if_valid_inst  = if_valid_q;
  assign if_pc          = if_pc_q;
  assign if_npc         = if_npc_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: bench-side memory responder with a scoreboard of expected
// fetched instructions, plus stall, redirect, wrap and mid-fetch reset scenarios.
module tb_if_stage;

  localparam logic [31:0] RPC = 32'h0000_0040;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        fetch_en;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        ex_take_branch;
  logic [31:0] ex_target_pc;
  logic        id_ready;
  logic [31:0] if_inst;
  logic        if_valid_inst;
  logic [31:0] if_pc;
  logic [31:0] if_npc;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  if_stage #(.RESET_PC(RPC)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .fetch_en       (fetch_en),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .ex_take_branch (ex_take_branch),
    .ex_target_pc   (ex_target_pc),
    .id_ready       (id_ready),
    .if_inst        (if_inst),
    .if_valid_inst  (if_valid_inst),
    .if_pc          (if_pc),
    .if_npc         (if_npc)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("out_valid", {31'd0, if_valid_inst}, 32'd1);
      chk("out_inst", if_inst, e.inst);
      chk("out_pc", if_pc, e.pc);
      chk("out_npc", if_npc, e.pc + 32'd4);
    end
  endtask

  // Accept one request at addr, answer lat cycles into S_WAIT, then compare the output.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data,
                          input int lat, input logic rdy_at_rsp);
    exp_t e;
    int   n;
    imem_req_ready = 1'b1;
    #1;
    n = 0;
    while (!imem_req_valid && n < 50) begin
      tick();
      n++;
    end
    chk("req_seen", {31'd0, imem_req_valid}, 32'd1);
    chk("req_addr", imem_addr, addr);
    tick();
    imem_req_ready = 1'b0;
    repeat (lat) tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    id_ready       = rdy_at_rsp;
    e.pc   = addr;
    e.inst = data;
    sb.push_back(e);
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    check_out();
  endtask

  initial begin
    reset_n        = 1'b0;
    fetch_en       = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    ex_take_branch = 1'b0;
    ex_target_pc   = 32'h0;
    id_ready       = 1'b0;
    repeat (3) @(posedge clock);
    #2;

    // Reset state
    chk("rst_valid", {31'd0, if_valid_inst}, 32'd0);
    chk("rst_inst", if_inst, 32'h0000_0013);
    chk("rst_pc", if_pc, RPC);
    chk("rst_npc", if_npc, RPC + 32'd4);
    chk("rst_req", {31'd0, imem_req_valid}, 32'd0);
    reset_n = 1'b1;
    #1;
    chk("fetch_dis_req", {31'd0, imem_req_valid}, 32'd0);
    fetch_en = 1'b1;
    id_ready = 1'b1;

    // First fetch at zero latency
    do_fetch(RPC, 32'h0000_0013, 0, 1'b1);
    chk("next_req", {31'd0, imem_req_valid}, 32'd1);
    chk("next_addr", imem_addr, RPC + 32'd4);

    // Decode stall: output held, no request until id_ready returns
    do_fetch(RPC + 32'd4, 32'h00A0_0093, 2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_req", {31'd0, imem_req_valid}, 32'd0);
      chk("stall_valid", {31'd0, if_valid_inst}, 32'd1);
      chk("stall_inst", if_inst, 32'h00A0_0093);
      chk("stall_pc", if_pc, RPC + 32'd4);
    end
    id_ready = 1'b1;
    #1;
    chk("unstall_req", {31'd0, imem_req_valid}, 32'd1);
    chk("unstall_addr", imem_addr, RPC + 32'd8);

    // Redirect while waiting, response three cycles later is dropped
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    ex_take_branch = 1'b1;
    ex_target_pc   = 32'h0000_0100;
    tick();
    ex_take_branch = 1'b0;
    tick();
    tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    chk("drop_valid", {31'd0, if_valid_inst}, 32'd0);
    chk("drop_req", {31'd0, imem_req_valid}, 32'd1);
    chk("drop_addr", imem_addr, 32'h0000_0100);
    tick();
    chk("drop_valid2", {31'd0, if_valid_inst}, 32'd0);
    do_fetch(32'h0000_0100, 32'h1234_5678, 1, 1'b1);

    // Redirect coincident with a response
    imem_req_ready = 1'b1;
    #1;
    chk("co_addr", imem_addr, 32'h0000_0104);
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hCAFE_F00D;
    ex_take_branch = 1'b1;
    ex_target_pc   = 32'h0000_0203;
    tick();
    imem_rsp_valid = 1'b0;
    ex_take_branch = 1'b0;
    #1;
    chk("co_valid", {31'd0, if_valid_inst}, 32'd0);
    chk("co_req", {31'd0, imem_req_valid}, 32'd1);
    chk("co_next_addr", imem_addr, 32'h0000_0200);

    // Redirect coincident with a request handshake
    imem_req_ready = 1'b1;
    ex_take_branch = 1'b1;
    ex_target_pc   = 32'h0000_0300;
    tick();
    imem_req_ready = 1'b0;
    ex_take_branch = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0_0001;
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    chk("hs_valid", {31'd0, if_valid_inst}, 32'd0);
    chk("hs_addr", imem_addr, 32'h0000_0300);

    // Redirect in S_REQ without handshake
    ex_take_branch = 1'b1;
    ex_target_pc   = 32'h0000_0402;
    tick();
    ex_take_branch = 1'b0;
    #1;
    chk("req_redir_addr", imem_addr, 32'h0000_0400);
    do_fetch(32'h0000_0400, 32'h0000_0517, 0, 1'b1);

    // PC wrap at the top of the address space
    ex_take_branch = 1'b1;
    ex_target_pc   = 32'hFFFF_FFFE;
    tick();
    ex_take_branch = 1'b0;
    #1;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    do_fetch(32'hFFFF_FFFC, 32'h0000_006F, 0, 1'b0);
    chk("wrap_npc", if_npc, 32'h0000_0000);
    chk("wrap_next_addr", imem_addr, 32'h0000_0000);

    // Reset in the middle of S_WAIT, late response ignored
    id_ready       = 1'b1;
    imem_req_ready = 1'b1;
    #1;
    chk("pre_rst_req", {31'd0, imem_req_valid}, 32'd1);
    tick();
    imem_req_ready = 1'b0;
    id_ready       = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, if_valid_inst}, 32'd0);
    chk("arst_inst", if_inst, 32'h0000_0013);
    chk("arst_pc", if_pc, RPC);
    chk("arst_npc", if_npc, RPC + 32'd4);
    chk("arst_req", {31'd0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1111_1111;
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    chk("late_valid", {31'd0, if_valid_inst}, 32'd0);
    chk("late_inst", if_inst, 32'h0000_0013);
    reset_n  = 1'b1;
    id_ready = 1'b1;
    #1;
    chk("post_rst_req", {31'd0, imem_req_valid}, 32'd1);
    chk("post_rst_addr", imem_addr, RPC);
    do_fetch(RPC, 32'h2222_2222, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
